fifo_reader: RTL and testbench

- Consumer-side controller for the project FIFO: issues fifo_rd, absorbs the FIFO's 1-cycle read latency and presents words downstream as a registered valid/pause stream.
- Holds up to 2 words (output register plus one skid entry), so a downstream pause never drops or duplicates an in-flight read.
- Sits between the FIFO data_out/fifo_empty pins and the next pipeline stage. Also keeps a delivered-word counter for debug.

---
 rtl/fifo_reader_pkg.sv | 26 ++
 rtl/fifo_reader_if.sv | 43 ++++
 rtl/fifo_reader_skid.sv | 82 ++++++++
 rtl/fifo_reader.sv | 64 ++++++
 tb/tb_fifo_reader.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared defaults and helpers for the FIFO consumer-side reader.
package fifo_reader_pkg;

    localparam int unsigned DATA_W_DEF = 6;
    localparam int unsigned CNT_W_DEF  = 8;
    localparam int unsigned SLOTS      = 2;

    // Occupancy of the holding buffer; the encodings double as the word count.
    typedef enum logic [1:0] {
        SK_EMPTY = 2'd0,
        SK_ONE   = 2'd1,
        SK_TWO   = 2'd2
    } skid_state_e;

    // True when a read issued now is guaranteed a slot when its data lands.
    function automatic logic room_for_read(
        input logic [1:0] occ,
        input logic       inflight,
        input logic       pop
    );
        logic [2:0] committed;
        committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        return committed < 3'(SLOTS);
    endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO-side and downstream-side signals of fifo_reader, with reader/environment views.
interface fifo_reader_if
    import fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
);

    logic              enable;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd;
    logic              pause;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              idle;
    logic [CNT_W-1:0]  words_cnt;

    modport master (
        input  enable,
        input  fifo_empty,
        input  fifo_data,
        input  pause,
        output fifo_rd,
        output data_out,
        output valid_out,
        output idle,
        output words_cnt
    );

    modport slave (
        output enable,
        output fifo_empty,
        output fifo_data,
        output pause,
        input  fifo_rd,
        input  data_out,
        input  valid_out,
        input  idle,
        input  words_cnt
    );

endinterface

// File: rtl/fifo_reader_skid.sv
// Two-entry ordered holding buffer: head is the registered output word, skid holds the next one.
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        occ
);

    skid_state_e       state;
    skid_state_e       state_nxt;
    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] head_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= SK_EMPTY;
            head_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_nxt;
            head_q <= head_d;
            skid_q <= skid_d;
        end
    end

    // A new word lands in the head if the head is free after this cycle's pop, otherwise in skid.
    always_comb begin
        state_nxt = state;
        head_d    = head_q;
        skid_d    = skid_q;
        case (state)
            SK_EMPTY: begin
                if (push) begin
                    head_d    = push_data;
                    state_nxt = SK_ONE;
                end
            end
            SK_ONE: begin
                case ({pop, push})
                    2'b10: state_nxt = SK_EMPTY;
                    2'b01: begin
                        skid_d    = push_data;
                        state_nxt = SK_TWO;
                    end
                    2'b11: head_d = push_data;
                    default: ;
                endcase
            end
            SK_TWO: begin
                if (pop) begin
                    head_d = skid_q;
                    if (push) begin
                        skid_d = push_data;
                    end else begin
                        state_nxt = SK_ONE;
                    end
                end
            end
            default: state_nxt = SK_EMPTY;
        endcase
    end

    assign head = head_q;
    assign occ  = state;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && state == SK_TWO));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && state == SK_EMPTY));
    a_state_legal: assert property (@(posedge clk) disable iff (!rst_n)
        state == SK_EMPTY || state == SK_ONE || state == SK_TWO);

endmodule

// File: rtl/fifo_reader.sv
// FIFO consumer: issues reads, absorbs the 1-cycle read latency, presents a valid/pause stream.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          RESET_L,
    fifo_reader_if.master bus
);

    logic              inflight;
    logic              rd;
    logic              pop;
    logic              valid;
    logic [1:0]        occ;
    logic [DATA_W-1:0] head;
    logic [CNT_W-1:0]  cnt;

    assign valid = (occ != 2'd0);
    assign pop   = valid & ~bus.pause;

    // Count the in-flight read as already occupying a slot so a pause can never overflow the buffer.
    assign rd = RESET_L & bus.enable & ~bus.fifo_empty & room_for_read(occ, inflight, pop);

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            inflight <= 1'b0;
            cnt      <= '0;
        end else begin
            inflight <= rd;
            if (pop) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    fifo_reader_skid #(
        .DATA_W(DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (RESET_L),
        .push      (inflight),
        .push_data (bus.fifo_data),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    assign bus.fifo_rd   = rd;
    assign bus.data_out  = head;
    assign bus.valid_out = valid;
    assign bus.idle      = (occ == 2'd0) && !inflight;
    assign bus.words_cnt = cnt;

    a_occ_limit: assert property (@(posedge clk) disable iff (!RESET_L)
        occ <= 2'(SLOTS));
    a_valid_occ: assert property (@(posedge clk) disable iff (!RESET_L)
        bus.valid_out == (occ != 2'd0));
    a_no_rd_empty: assert property (@(posedge clk) disable iff (!RESET_L)
        !(rd && bus.fifo_empty));

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: a FIFO model feeds two readers (CNT_W=8 and CNT_W=4).
module tb_fifo_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en1;
    logic       en2;
    logic       pause_r;
    logic       fifo_empty;
    logic [5:0] fifo_data;
    logic       fifo_rd_any;

    logic [5:0] src [64];
    int         src_wr = 0;
    int         src_rd = 0;
    int         rd_count = 0;

    logic [5:0] exp_q [$];
    int         nchk = 0;
    int         nerr = 0;

    logic [5:0] bp_words [9] = '{6'h05, 6'h0A, 6'h0F, 6'h14, 6'h19, 6'h1E, 6'h23, 6'h28, 6'h2D};

    always #5 clk = ~clk;

    fifo_reader_if #(.DATA_W(6), .CNT_W(8)) bus1 ();
    fifo_reader_if #(.DATA_W(6), .CNT_W(4)) bus2 ();

    fifo_reader #(.DATA_W(6), .CNT_W(8)) u_dut (
        .clk     (clk),
        .RESET_L (rst_n),
        .bus     (bus1)
    );

    fifo_reader #(.DATA_W(6), .CNT_W(4)) u_dut_wrap (
        .clk     (clk),
        .RESET_L (rst_n),
        .bus     (bus2)
    );

    assign fifo_empty      = (src_rd == src_wr);
    assign fifo_rd_any     = bus1.fifo_rd | bus2.fifo_rd;
    assign bus1.enable     = en1;
    assign bus2.enable     = en2;
    assign bus1.pause      = pause_r;
    assign bus2.pause      = pause_r;
    assign bus1.fifo_empty = fifo_empty;
    assign bus2.fifo_empty = fifo_empty;
    assign bus1.fifo_data  = fifo_data;
    assign bus2.fifo_data  = fifo_data;

    // FIFO model: data_out valid the cycle after fifo_rd is sampled.
    always @(posedge clk) begin
        if (fifo_rd_any && !fifo_empty) begin
            fifo_data <= src[src_rd];
            src_rd    <= src_rd + 1;
            rd_count  <= rd_count + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [5:0] w);
        src[src_wr] = w;
        src_wr++;
        exp_q.push_back(w);
    endtask

    task automatic sb_pop(input string name, input logic [5:0] act);
        if (exp_q.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL %s actual=%0h expected=none", name, act);
        end else begin
            chk(name, 32'(act), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] rd_bits;
        logic [9:0] v_bits;
        int         rd_base;
        int         rd_pause;

        fork
            forever begin
                @(negedge clk);
                chk("rd_while_empty", 32'(fifo_rd_any & fifo_empty), 32'd0);
                if (bus1.valid_out && !bus1.pause) sb_pop("u1_word", bus1.data_out);
                if (bus2.valid_out && !bus2.pause) sb_pop("u2_word", bus2.data_out);
            end
        join_none

        rst_n   = 1'b0;
        en1     = 1'b1;
        en2     = 1'b0;
        pause_r = 1'b0;
        push(6'b010010);

        // Reset with a non-empty FIFO, then a single-word read.
        repeat (2) begin
            @(negedge clk);
            chk("rst_fifo_rd", 32'(bus1.fifo_rd), 32'd0);
            chk("rst_valid", 32'(bus1.valid_out), 32'd0);
            chk("rst_idle", 32'(bus1.idle), 32'd1);
            chk("rst_cnt", 32'(bus1.words_cnt), 32'd0);
        end
        chk("rst_data", 32'(bus1.data_out), 32'd0);
        drive_edge();
        rst_n = 1'b1;
        @(negedge clk);
        chk("single_rd_first", 32'(bus1.fifo_rd), 32'd1);
        @(negedge clk);
        chk("single_valid_n1", 32'(bus1.valid_out), 32'd0);
        chk("single_rd_n1", 32'(bus1.fifo_rd), 32'd0);
        @(negedge clk);
        chk("single_valid_n2", 32'(bus1.valid_out), 32'd1);
        chk("single_data_n2", 32'(bus1.data_out), 32'b010010);
        @(negedge clk);
        chk("single_valid_n3", 32'(bus1.valid_out), 32'd0);
        chk("single_cnt", 32'(bus1.words_cnt), 32'd1);
        chk("single_idle", 32'(bus1.idle), 32'd1);
        chk("single_rd_total", 32'(rd_count), 32'd1);

        // Reset while a read is in flight: the word is lost and the counter clears.
        drive_edge();
        push(6'b101011);
        drive_edge();
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        chk("rstfl_valid", 32'(bus1.valid_out), 32'd0);
        chk("rstfl_idle", 32'(bus1.idle), 32'd1);
        chk("rstfl_cnt", 32'(bus1.words_cnt), 32'd0);
        chk("rstfl_rd", 32'(bus1.fifo_rd), 32'd0);
        @(negedge clk);
        chk("rstfl_valid2", 32'(bus1.valid_out), 32'd0);
        drive_edge();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstfl_idle_after", 32'(bus1.idle), 32'd1);
        chk("rstfl_valid_after", 32'(bus1.valid_out), 32'd0);

        // Streaming four words.
        drive_edge();
        push(6'b100100);
        push(6'b110110);
        push(6'b010100);
        push(6'b110000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rd_bits[i] = bus1.fifo_rd;
            v_bits[i]  = bus1.valid_out;
        end
        chk("stream_rd_pattern", 32'(rd_bits), 32'b0000001111);
        chk("stream_valid_pattern", 32'(v_bits), 32'b0000111100);
        chk("stream_cnt", 32'(bus1.words_cnt), 32'd4);
        chk("stream_idle", 32'(bus1.idle), 32'd1);

        // Back-pressure: pause for 5 cycles during a 9-word stream.
        drive_edge();
        for (int i = 0; i < 9; i++) push(bp_words[i]);
        repeat (3) @(negedge clk);
        drive_edge();
        pause_r  = 1'b1;
        rd_pause = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_hold", 32'(bus1.valid_out), 32'd1);
            chk("bp_data_hold", 32'(bus1.data_out), 32'(bp_words[1]));
            rd_pause += int'(bus1.fifo_rd);
        end
        chk("bp_reads_in_pause", 32'(rd_pause), 32'd0);
        drive_edge();
        pause_r = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("bp_no_gap", 32'(bus1.valid_out), 32'd1);
        end
        @(negedge clk);
        chk("bp_drained", 32'(bus1.valid_out), 32'd0);
        chk("bp_cnt", 32'(bus1.words_cnt), 32'd13);

        // enable drops right after a read is issued; resumes later.
        drive_edge();
        push(6'b000111);
        push(6'b111000);
        push(6'b011110);
        @(negedge clk);
        chk("en_rd_before_drop", 32'(bus1.fifo_rd), 32'd1);
        rd_base = rd_count;
        drive_edge();
        en1 = 1'b0;
        @(negedge clk);
        chk("en_rd_after_drop", 32'(bus1.fifo_rd), 32'd0);
        @(negedge clk);
        chk("en_inflight_delivered", 32'(bus1.valid_out), 32'd1);
        chk("en_inflight_data", 32'(bus1.data_out), 32'b000111);
        @(negedge clk);
        chk("en_idle", 32'(bus1.idle), 32'd1);
        chk("en_rd_count", 32'(rd_count - rd_base), 32'd1);
        chk("en_cnt", 32'(bus1.words_cnt), 32'd14);
        drive_edge();
        en1 = 1'b1;
        @(negedge clk);
        chk("en_resume_rd", 32'(bus1.fifo_rd), 32'd1);
        repeat (6) @(negedge clk);
        chk("en_resume_cnt", 32'(bus1.words_cnt), 32'd16);
        chk("en_resume_idle", 32'(bus1.idle), 32'd1);
        drive_edge();
        en1 = 1'b0;

        // Counter wrap on the CNT_W=4 instance.
        drive_edge();
        en2 = 1'b1;
        rd_base = rd_count;
        for (int i = 0; i < 17; i++) push(6'(i * 3 + 1));
        repeat (25) @(negedge clk);
        chk("wrap_cnt", 32'(bus2.words_cnt), 32'd1);
        chk("wrap_idle", 32'(bus2.idle), 32'd1);
        chk("wrap_rd_count", 32'(rd_count - rd_base), 32'd17);
        chk("wrap_u1_cnt", 32'(bus1.words_cnt), 32'd16);
        chk("sb_all_delivered", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
